// File: rtl/tile_sequencer.sv
// tile_sequencer: backtracking scheduler for a chain of tile solvers.
// Passes a single one-hot "myturn" token along the chain, advancing on the
// current tile's passfwd and retreating on its passbak. A tile that gives up
// is cleared so that its candidate scan restarts on its next turn.
// Optional macro TILE_SEQ_STEP_COUNT_EN adds a saturating ISSUE-entry counter
// on the steps port. When the macro is undefined, steps reads as zero.
module tile_sequencer #(
    parameter int unsigned NUM_TILES = 16,
    parameter int unsigned IDX_W     = $clog2(NUM_TILES)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    output logic [NUM_TILES-1:0] myturn,
    output logic [NUM_TILES-1:0] tile_clear,
    input  logic [NUM_TILES-1:0] passfwd,
    input  logic [NUM_TILES-1:0] passbak,
    output logic [IDX_W-1:0]     cur_idx,
    output logic                 busy,
    output logic                 done,
    output logic                 failed,
    output logic                 proto_err,
    output logic [31:0]          steps
);

    typedef enum logic [2:0] {
        StIdle,
        StClrAll,
        StIssue,
        StWait,
        StClrOne,
        StDone,
        StFail
    } state_e;

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_TILES - 1);

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   proto_d;
    logic                   hit_fwd, hit_bak;
    logic [NUM_TILES-1:0]   sel_d;

    // Only the tile holding the turn is listened to.
    assign hit_fwd = passfwd[idx_q];
    assign hit_bak = passbak[idx_q];
    assign sel_d   = NUM_TILES'(1) << idx_d;
    assign cur_idx = idx_q;

    // Next-state, next-index and sticky protocol-error decode.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        proto_d = proto_err;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StClrAll;
            end
            StClrAll: begin
                idx_d   = '0;
                state_d = StIssue;
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                // passbak wins when both arrive together; that case is flagged.
                if (hit_bak) begin
                    if (hit_fwd) proto_d = 1'b1;
                    state_d = (idx_q == '0) ? StFail : StClrOne;
                end else if (hit_fwd) begin
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = StIssue;
                    end
                end
            end
            StClrOne: begin
                idx_d   = idx_q - IDX_W'(1);
                state_d = StIssue;
            end
            StDone, StFail: begin
                if (start) state_d = StClrAll;
            end
            default: state_d = StIdle;
        endcase
        if (state_d == StClrAll) proto_d = 1'b0;
    end

    // State register; outputs are registered from the next state so they
    // track the registered state exactly (Moore behaviour).
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            myturn     <= '0;
            tile_clear <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            failed     <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            myturn     <= (state_d == StIssue) ? sel_d : '0;
            if (state_d == StClrAll) begin
                tile_clear <= '1;
            end else if (state_d == StClrOne) begin
                tile_clear <= sel_d;
            end else begin
                tile_clear <= '0;
            end
            busy       <= (state_d == StClrAll) || (state_d == StIssue) ||
                          (state_d == StWait)   || (state_d == StClrOne);
            done       <= (state_d == StDone);
            failed     <= (state_d == StFail);
            proto_err  <= proto_d;
        end
    end

`ifdef TILE_SEQ_STEP_COUNT_EN
    logic [31:0] steps_q;

    // Count ISSUE entries since the last full clear, saturating at all-ones.
    always_ff @(posedge clock) begin
        if (reset || (state_d == StClrAll)) begin
            steps_q <= '0;
        end else if ((state_d == StIssue) && (steps_q != '1)) begin
            steps_q <= steps_q + 32'd1;
        end
    end

    assign steps = steps_q;
`else
    assign steps = '0;
`endif

endmodule

// File: tb/tb_tile_sequencer.sv
// tb_tile_sequencer: randomized self-checking bench for tile_sequencer
// (NUM_TILES=4). A transaction-level model tracks which tile should hold
// the token and predicts each grant, clear, done and fail event.
module tb_tile_sequencer;

    localparam int unsigned N  = 4;
    localparam int unsigned IW = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [N-1:0]  myturn, tile_clear, passfwd, passbak;
    logic [IW-1:0] cur_idx;
    logic          busy, done, failed, proto_err;
    logic [31:0]   steps;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   exp_steps = 0;
    logic exp_proto = 1'b0;

    tile_sequencer #(.NUM_TILES(N), .IDX_W(IW)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .myturn     (myturn),
        .tile_clear (tile_clear),
        .passfwd    (passfwd),
        .passbak    (passbak),
        .cur_idx    (cur_idx),
        .busy       (busy),
        .done       (done),
        .failed     (failed),
        .proto_err  (proto_err),
        .steps      (steps)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_in();
        passfwd = '0;
        passbak = '0;
        start   = 1'b0;
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Compare every output against the model's view of the current phase.
    task automatic expect_view(input string tag, input logic [N-1:0] mt, input logic [N-1:0] tc,
                               input int idx, input logic b, input logic d, input logic f,
                               input logic chk_idx);
        logic [31:0] es;
`ifdef TILE_SEQ_STEP_COUNT_EN
        es = 32'(exp_steps);
`else
        es = 32'd0;
`endif
        check({tag, ".myturn"}, 32'(myturn), 32'(mt));
        check({tag, ".tile_clear"}, 32'(tile_clear), 32'(tc));
        if (chk_idx) check({tag, ".cur_idx"}, 32'(cur_idx), 32'(idx));
        check({tag, ".busy"}, 32'(busy), 32'(b));
        check({tag, ".done"}, 32'(done), 32'(d));
        check({tag, ".failed"}, 32'(failed), 32'(f));
        check({tag, ".proto_err"}, 32'(proto_err), 32'(exp_proto));
        check({tag, ".steps"}, steps, es);
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start     = 1'b0;
        exp_proto = 1'b0;
        exp_steps = 0;
        expect_view("clrall", '0, '1, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        exp_steps = 1;
    endtask

    // mode 0: random; 1: all forward; 2: tile 0 gives up; 3: tile 2 backs off once;
    // 4: tile 1 asserts both once; 5: reset while tile 2 waits.
    task automatic run_solve(input int mode);
        int   idx;
        int   grants;
        int   dly;
        int   j;
        int   r;
        bit   fin;
        bit   once;
        bit   aborted;
        logic fw, bk, res_done;
        idx = 0; grants = 0; fin = 0; once = 0; aborted = 0; res_done = 1'b0;
        do_start();
        while (!fin && grants < 400) begin
            grants++;
            expect_view("issue", onehot(idx), '0, idx, 1'b1, 1'b0, 1'b0, 1'b1);
            step();
            expect_view("wait", '0, '0, idx, 1'b1, 1'b0, 1'b0, 1'b1);
            dly = (mode == 0) ? int'($urandom_range(0, 3)) : 1;
            for (int k = 0; k < dly; k++) begin
                if (mode == 0 && $urandom_range(0, 2) == 0) begin
                    j = (idx + 1 + int'($urandom_range(0, N - 2))) % N;
                    passfwd[j] = 1'($urandom);
                    passbak[j] = 1'($urandom);
                end
                start = (mode == 0 && $urandom_range(0, 5) == 0);
                step();
                clear_in();
                expect_view("hold", '0, '0, idx, 1'b1, 1'b0, 1'b0, 1'b1);
            end
            fw = 1'b0; bk = 1'b0;
            case (mode)
                0: begin
                    r = int'($urandom_range(0, 19));
                    if (r < 3) bk = 1'b1;
                    else if (r == 3) begin fw = 1'b1; bk = 1'b1; end
                    else fw = 1'b1;
                end
                2: bk = 1'b1;
                3: if (idx == 2 && !once) begin bk = 1'b1; once = 1; end else fw = 1'b1;
                4: if (idx == 1 && !once) begin fw = 1'b1; bk = 1'b1; once = 1; end
                   else fw = 1'b1;
                5: if (idx == 2) aborted = 1; else fw = 1'b1;
                default: fw = 1'b1;
            endcase
            if (aborted) begin
                reset = 1'b1;
                step();
                reset     = 1'b0;
                exp_proto = 1'b0;
                exp_steps = 0;
                expect_view("rst", '0, '0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
                step();
                expect_view("rst_idle", '0, '0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
                fin = 1;
            end else begin
                passfwd[idx] = fw;
                passbak[idx] = bk;
                if (mode == 0 && $urandom_range(0, 1) == 0) begin
                    j = (idx + 1 + int'($urandom_range(0, N - 2))) % N;
                    passfwd[j] = 1'($urandom);
                    passbak[j] = 1'($urandom);
                end
                step();
                clear_in();
                if (bk) begin
                    if (fw) exp_proto = 1'b1;
                    if (idx == 0) begin
                        expect_view("fail", '0, '0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
                        fin = 1;
                    end else begin
                        expect_view("clrone", '0, onehot(idx), idx, 1'b1, 1'b0, 1'b0, 1'b1);
                        step();
                        idx--;
                        exp_steps++;
                    end
                end else if (idx == N - 1) begin
                    expect_view("done", '0, '0, N - 1, 1'b0, 1'b1, 1'b0, 1'b1);
                    res_done = 1'b1;
                    fin = 1;
                end else begin
                    idx++;
                    exp_steps++;
                end
            end
        end
        if (!fin) begin
            // Random walk ran too long; restart cleanly without judging the DUT.
            reset = 1'b1;
            step();
            reset = 1'b0;
            exp_proto = 1'b0;
            exp_steps = 0;
        end else if (!aborted) begin
            for (int k = 0; k < 2; k++) begin
                step();
                expect_view("final", '0, '0, res_done ? N - 1 : 0, 1'b0, res_done, !res_done,
                            1'b1);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        clear_in();
        step();
        step();
        expect_view("reset", '0, '0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        step();
        expect_view("idle", '0, '0, 0, 1'b0, 1'b0, 1'b0, 1'b1);

        run_solve(1);
        run_solve(3);
        run_solve(2);
        run_solve(1);
        run_solve(4);
        run_solve(5);
        run_solve(1);
        for (int s = 0; s < 30; s++) run_solve(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tile_sequencer.md
Name: tile_sequencer

Overview:
- Backtracking scheduler for a chain of NUM_TILES tile solvers.
- Hands the single "myturn" token to one tile at a time.
- Advances on passfwd. Retreats on passbak, clearing the tile that gave up so it restarts its candidate scan the next time it gets a turn.
- Sits between the top-level solve control (start/done/failed) and the tile array; one instance per grid.

Parameters:
- NUM_TILES, 16, number of tiles sequenced (index 0 = first tile filled). Legal range 2..256.
- IDX_W, $clog2(NUM_TILES), width of the tile index.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high; clock clock.
- start  input  1  pulse; begins a solve. Honoured only in IDLE, DONE, FAIL.
- myturn  output  NUM_TILES  one-hot pulse granting a turn to tile [cur_idx].
- tile_clear  output  NUM_TILES  per-tile synchronous clear (drives the tile's reset input).
- passfwd  input  NUM_TILES  per-tile "found a value" pulse.
- passbak  input  NUM_TILES  per-tile "exhausted all values" pulse.
- cur_idx  output  IDX_W  index of the tile currently holding the turn.
- busy  output  1  high in CLRALL, ISSUE, WAIT, CLRONE.
- done  output  1  high in DONE (grid solved).
- failed  output  1  high in FAIL (no solution).
- proto_err  output  1  sticky; set when the current tile asserts passfwd and passbak in the same cycle.
- steps  output  32  optional; see Optional Feature.

Behaviour:
- All outputs are Moore, decoded from the registered state and cur_idx.
- Reset: state=IDLE, cur_idx=0, proto_err=0, steps=0. All other outputs 0.
- States and transitions:
  - IDLE: on start -> CLRALL.
  - CLRALL: tile_clear = all ones for 1 cycle; cur_idx <= 0; -> ISSUE.
  - ISSUE: myturn[cur_idx]=1 for exactly 1 cycle; -> WAIT.
  - WAIT: watches only passfwd[cur_idx] / passbak[cur_idx]; pulses from other tiles are ignored.
    - passfwd, cur_idx < NUM_TILES-1: cur_idx++, -> ISSUE.
    - passfwd, cur_idx == NUM_TILES-1: -> DONE.
    - passbak, cur_idx > 0: -> CLRONE (cur_idx unchanged).
    - passbak, cur_idx == 0: -> FAIL.
    - Both asserted: set proto_err, treat as passbak.
    - Neither asserted: stay in WAIT (no timeout).
  - CLRONE: tile_clear[cur_idx]=1 for 1 cycle; cur_idx--, -> ISSUE (re-grants the previous tile, which continues from its retained index).
  - DONE / FAIL: hold, and keep done/failed high. On start -> CLRALL, which also clears proto_err.
- Latency:
  - start to first myturn[0]: 2 cycles (start sampled at t, CLRALL at t+1, ISSUE at t+2).
  - passfwd to next myturn: 1 cycle.
  - passbak to previous tile's myturn: 2 cycles.
- start while busy: ignored.
- Reset mid-solve: returns to IDLE in the next cycle; myturn and tile_clear are 0 from then on.
- No arithmetic wrap: cur_idx never leaves 0..NUM_TILES-1, guaranteed by the boundary checks above.

Optional Feature:
- Macro: TILE_SEQ_STEP_COUNT_EN.
- Defined:
  - steps counts ISSUE-state entries since the last CLRALL.
  - 32-bit, saturating at 2^32-1.
  - Reset to 0 by reset and by CLRALL; held in DONE/FAIL.
- Undefined: steps is tied to 0 and no counter logic is synthesised. The port stays present.

Test Plan:
- Straight solve, NUM_TILES=4, each tile answers passfwd 3 cycles after its myturn -> myturn order 0,1,2,3; done rises 1 cycle after tile 3's passfwd; failed=0; steps=4.
- Single backtrack: tile 2 answers passbak once, then all tiles answer passfwd -> tile_clear=0100 for 1 cycle; next myturn=0010, then 0100, 1000; done=1; steps=6.
- Total failure: tile 0 answers passbak -> failed=1, done=0, cur_idx=0, no tile_clear pulse; a following start -> tile_clear=1111, then myturn=0001.
- Stray and illegal pulses: passfwd[3] while cur_idx=1 -> ignored, still in WAIT. passfwd[1]&passbak[1] together -> proto_err=1, CLRONE on tile 1, then myturn=0001.
- Reset mid-WAIT at cur_idx=2 -> next cycle busy=0, cur_idx=0, all outputs 0; start afterwards -> normal solve from tile 0.
- Start while busy: pulse start during WAIT -> no CLRALL and no change to cur_idx or steps.
